mem_arbiter: RTL and testbench

//   Two-port arbiter sharing the single Data_Memory line port (256-bit, enable/write/ack) between
//   the D-cache (port 0) and a second line requester (port 1, e.g. I-cache refill). Sits between
//   CPU cache controllers and Data_Memory; one memory transaction in flight at a time.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one Data_Memory line port, one transaction in flight at a time.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  // state | meaning
  // IDLE  | no memory transaction; next request (if any) is arbitrated this cycle
  // BUSY  | memory driven from granted port until mem_ack_i
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   drop_q, drop_d;
  logic   req_any, winner, grant_en, aborted;

  assign req_any  = m0_enable_i | m1_enable_i;
  assign grant_en = grant_q ? m1_enable_i : m0_enable_i;
  // Once the owner lets go of enable, the in-flight ack belongs to nobody.
  assign aborted  = drop_q | ~grant_en;

`ifdef MEM_ARB_RR_EN
  assign winner = (m0_enable_i & m1_enable_i) ? ~last_grant_q : ~m0_enable_i;
`else
  assign winner = ~m0_enable_i;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = winner;
          drop_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_enable_o = 1'b1;
        mem_write_o  = grant_q ? m1_write_i : m0_write_i;
        mem_addr_o   = grant_q ? m1_addr_i  : m0_addr_i;
        mem_data_o   = grant_q ? m1_data_i  : m0_data_i;
        if (mem_ack_i) begin
          m0_ack_o     = ~grant_q & ~aborted;
          m1_ack_o     =  grant_q & ~aborted;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          drop_d = aborted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
    end
  end

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents, 10-cycle memory model and a transaction-level
// reference model checked every cycle, plus hand-computed expectations per scenario.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam logic [255:0] PAT = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
  localparam logic [255:0] W400 = {8{32'hCAFE_0400}};

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            drop_after;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en   [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic          ack0, ack1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_enable, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          auto_ack = 1'b0;
  logic          force_ack = 1'b0;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata = '0;
  assign mem_ack = auto_ack | force_ack;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_enable_i(en[0]), .m0_write_i(wr[0]), .m0_addr_i(addr[0]), .m0_data_i(wdat[0]),
    .m0_ack_o(ack0), .m0_data_o(rd0),
    .m1_enable_i(en[1]), .m1_write_i(wr[1]), .m1_addr_i(addr[1]), .m1_data_i(wdat[1]),
    .m1_ack_o(ack1), .m1_data_o(rd1),
    .mem_enable_o(mem_enable), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  function automatic void check(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endfunction

  always @(posedge clk) cyc++;

  // Memory: ack in the 10th cycle mem_enable is high; writes stored, unwritten lines = PAT ^ addr.
  logic [DW-1:0] store [logic [AW-1:0]];
  int mcnt = 0;
  always @(posedge clk) begin
    #1;
    if (auto_ack) begin
      auto_ack = 1'b0;
      mcnt = 0;
    end else if (mem_enable) begin
      mcnt++;
      if (mcnt == 10) begin
        auto_ack = 1'b1;
        if (mem_write) store[mem_addr] = mem_wdata;
        else mem_rdata = store.exists(mem_addr) ? store[mem_addr] : (PAT ^ {8{mem_addr}});
      end
    end else begin
      mcnt = 0;
    end
    if (!auto_ack) mem_rdata = {8{32'(cyc)}} ^ {8{32'h5A5A_0F0F}};
  end

  // Requester agents: one request at a time; reload immediately after an ack.
  req_t rq [2][$];
  bit   ack_prev [2];
  int   hi [2];
  int   drop_at [2];
  int   raise_cyc [2];
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        rq[p].delete();
        en[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdat[p] = '0;
        hi[p] = 0; drop_at[p] = 0;
      end else begin
        if (en[p] && ack_prev[p]) en[p] = 1'b0;
        else if (en[p] && drop_at[p] > 0 && hi[p] == drop_at[p]) en[p] = 1'b0;
        if (!en[p] && rq[p].size() > 0) begin
          req_t r;
          r = rq[p].pop_front();
          en[p] = 1'b1; wr[p] = r.wr; addr[p] = r.addr; wdat[p] = r.data;
          drop_at[p] = r.drop_after; hi[p] = 0; raise_cyc[p] = cyc;
        end
        if (en[p]) hi[p]++;
      end
    end
  end

  // Reference model: owner = port holding the memory (-1 none), dropped = owner gave up.
  int owner = -1;
  int last_served = 1;
  bit dropped = 1'b0;
  int n_ack [2];
  int ack_log [$];
  int gap_log [$];
  logic [DW-1:0] ack_data [2];
  int last_ack_cyc = -1;
  int rise_lat = -1;
  int n_en_cyc = 0;
  bit en_prev = 1'b0;

  function automatic int pick(logic e0, logic e1, int last);
`ifdef MEM_ARB_RR_EN
    if (e0 && e1) return 1 - last;
`endif
    return e0 ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    logic owner_en, cur_drop, exp_a0, exp_a1;
    owner_en = (owner == 1) ? en[1] : en[0];
    cur_drop = (owner >= 0) && (dropped || !owner_en);
    exp_a0 = (owner == 0) && mem_ack && !cur_drop;
    exp_a1 = (owner == 1) && mem_ack && !cur_drop;
    check("mem_enable", mem_enable, owner >= 0);
    check("m0_ack", ack0, exp_a0);
    check("m1_ack", ack1, exp_a1);
    check("both_acks", ack0 & ack1, 0);
    check("m0_data", rd0, mem_rdata);
    check("m1_data", rd1, mem_rdata);
    if (owner >= 0) begin
      check("mem_write", mem_write, (owner == 1) ? wr[1] : wr[0]);
      check("mem_addr", mem_addr, (owner == 1) ? addr[1] : addr[0]);
      check("mem_wdata", mem_wdata, (owner == 1) ? wdat[1] : wdat[0]);
    end

    ack_prev[0] = ack0;
    ack_prev[1] = ack1;
    if (ack0) begin n_ack[0]++; ack_log.push_back(0); ack_data[0] = rd0; last_ack_cyc = cyc; end
    if (ack1) begin n_ack[1]++; ack_log.push_back(1); ack_data[1] = rd1; last_ack_cyc = cyc; end
    if (mem_enable && mem_ack) last_ack_cyc = cyc;
    if (mem_enable) n_en_cyc++;
    if (mem_enable && !en_prev) begin
      if (owner >= 0) rise_lat = cyc - raise_cyc[owner];
      if (last_ack_cyc >= 0) gap_log.push_back(cyc - last_ack_cyc);
    end
    en_prev = mem_enable;

    if (rst) begin
      owner = -1; last_served = 1; dropped = 1'b0;
    end else if (owner < 0) begin
      if (en[0] || en[1]) owner = pick(en[0], en[1], last_served);
      dropped = 1'b0;
    end else if (mem_ack) begin
      last_served = owner; owner = -1; dropped = 1'b0;
    end else begin
      dropped = cur_drop;
    end
  end

  function automatic int log_code();
    int c = 0;
    foreach (ack_log[i]) c = c * 10 + ack_log[i] + 1;
    return c;
  endfunction

  task automatic cycles(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    cycles(1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    n_ack[0] = 0; n_ack[1] = 0;
    ack_log.delete(); gap_log.delete();
    last_ack_cyc = -1; rise_lat = -1; n_en_cyc = 0;
  endtask

  task automatic push(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d, int drop);
    req_t r;
    r.wr = w; r.addr = a; r.data = d; r.drop_after = drop;
    rq[p].push_back(r);
  endtask

  task automatic wait_idle(string nm, int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      cycles(1);
      if (rq[0].size() == 0 && rq[1].size() == 0 && !en[0] && !en[1] && !mem_enable) quiet++;
      else quiet = 0;
    end
    check(nm, quiet >= 3, 1);
  endtask

  initial begin
    int gsum;
    int waited;
    // 1: single read on port 0
    do_reset();
    push(0, 1'b0, 32'h0, '0, 0);
    wait_idle("t1_idle", 100);
    check("t1_m0_acks", n_ack[0], 1);
    check("t1_m1_acks", n_ack[1], 0);
    check("t1_data", ack_data[0], PAT);
    check("t1_latency", rise_lat, 1);
    check("t1_en_cycles", n_en_cyc, 10);

    // 2: simultaneous requests, port 0 re-requests at once
    do_reset();
    push(0, 1'b1, 32'h400, W400, 0);
    push(1, 1'b0, 32'h200, '0, 0);
    push(0, 1'b0, 32'h400, '0, 0);
    wait_idle("t2_idle", 200);
`ifdef MEM_ARB_RR_EN
    check("t2_order", log_code(), 121);
`else
    check("t2_order", log_code(), 112);
`endif
    check("t2_gap", (gap_log.size() > 0) ? gap_log[0] : -1, 2);
    check("t2_readback", ack_data[0], W400);
    check("t2_p1_data", ack_data[1], PAT ^ {8{32'h200}});

    // 3: back-to-back requests on both ports
    do_reset();
    push(0, 1'b0, 32'h10, '0, 0);
    push(1, 1'b0, 32'h30, '0, 0);
    push(0, 1'b0, 32'h20, '0, 0);
    push(1, 1'b0, 32'h40, '0, 0);
    wait_idle("t3_idle", 300);
`ifdef MEM_ARB_RR_EN
    check("t3_order", log_code(), 1212);
`else
    check("t3_order", log_code(), 1122);
`endif
    gsum = 0;
    foreach (gap_log[i]) gsum += gap_log[i];
    check("t3_gaps", gsum, 6);

    // 4: port 1 abandons its request three cycles into the transaction
    do_reset();
    push(1, 1'b0, 32'h80, '0, 4);
    wait_idle("t4_idle", 100);
    check("t4_m1_acks", n_ack[1], 0);
    check("t4_m0_acks", n_ack[0], 0);
    check("t4_en_cycles", n_en_cyc, 10);

    // 5: reset in the middle of a transaction, then a stray late ack
    do_reset();
    push(0, 1'b0, 32'h100, '0, 0);
    waited = 0;
    while (!mem_enable && waited < 20) begin cycles(1); waited++; end
    check("t5_started", mem_enable, 1);
    cycles(5);
    rst = 1'b1;
    cycles(1);
    check("t5_en_after_rst", mem_enable, 0);
    cycles(1);
    rst = 1'b0;
    cycles(3);
    force_ack = 1'b1;
    cycles(1);
    force_ack = 1'b0;
    cycles(3);
    check("t5_acks", n_ack[0] + n_ack[1], 0);
    check("t5_idle", mem_enable, 0);

    // 6: ack while idle, then normal service resumes
    do_reset();
    cycles(2);
    force_ack = 1'b1;
    cycles(1);
    force_ack = 1'b0;
    cycles(2);
    check("t6_acks", n_ack[0] + n_ack[1], 0);
    check("t6_idle", mem_enable, 0);
    push(1, 1'b0, 32'h40, '0, 0);
    wait_idle("t6_idle_after", 100);
    check("t6_order", log_code(), 2);
    check("t6_data", ack_data[1], PAT ^ {8{32'h40}});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
